// File: rtl/huffman_histogram.sv
// Symbol histogram for the Huffman encoder: counts A1..A6 over a FRAME_LEN-symbol frame.
// Latency: cnt_valid is high the cycle after the edge that accepts the last symbol of the frame.
// Backpressure: none; symbols that arrive in DONE are dropped and flagged until frame_ack releases the hold.
module huffman_histogram #(
    parameter int FRAME_LEN = 100,
    parameter int CNT_W     = 7,
    parameter int SYM_N     = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           sym_in,
    input  logic                 sym_valid,
    input  logic                 frame_ack,
    output logic [6*CNT_W-1:0]   cnt_data,
    output logic [6*6-1:0]       cnt_flag,
    output logic [2:0]           cnt_num,
    output logic                 cnt_valid,
    output logic                 busy,
    output logic                 err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt [SYM_N];
    logic [6:0]        total;
    logic [6:0]        total_inc;
    logic              legal;
    logic              accept;
    logic              frame_end;
    logic              release_hold;

    // Codes 0 and 7 carry no symbol.
    assign legal        = (sym_in != 3'd0) && (sym_in != 3'd7);
    assign accept       = sym_valid && legal && (state != DONE);
    assign total_inc    = total + 7'd1;
    assign frame_end    = accept && (total_inc == 7'(FRAME_LEN));
    assign release_hold = (state == DONE) && frame_ack;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; FRAME_LEN >= 2 so the first symbol can never close a frame.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = COUNT;
            COUNT:   if (frame_end) state_nxt = DONE;
            DONE:    if (frame_ack) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Per-symbol counters and frame total; slot i holds symbol code 6-i.
    always_ff @(posedge clk) begin
        if (rst || release_hold) begin
            for (int i = 0; i < SYM_N; i++) begin
                cnt[i] <= '0;
            end
            total <= '0;
        end else if (accept) begin
            for (int i = 0; i < SYM_N; i++) begin
                if (sym_in == 3'(SYM_N - i) && cnt[i] != {CNT_W{1'b1}}) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            total <= total_inc;
        end
    end

    // Sticky error: illegal code, or any symbol during the hold except on the releasing edge.
    always_ff @(posedge clk) begin
        if (rst || release_hold) begin
            err <= 1'b0;
        end else if (sym_valid && (!legal || state == DONE)) begin
            err <= 1'b1;
        end
    end

    assign busy      = (state == COUNT);
    assign cnt_valid = (state == DONE);
    assign cnt_num   = 3'd6;

    // Count and flag packing: slot 5 is A1 with flag 6'b000001, slot 0 is A6 with 6'b100000.
    for (genvar g = 0; g < SYM_N; g++) begin : g_slot
        assign cnt_data[CNT_W*g +: CNT_W] = cnt[g];
        assign cnt_flag[6*g +: 6]         = 6'b100000 >> g;
    end

endmodule

// File: tb/tb_huffman_histogram.sv
// Directed bench for huffman_histogram: table of frames plus hand-written hold/ack/reset sequences.
// Runs a 100-symbol instance and a 127-symbol instance side by side on shared symbol inputs.
// All expected values are built from the frame tables and hand-computed constants.
module tb_huffman_histogram;

    localparam int CNT_W = 7;
    localparam int FL    = 100;
    localparam int FL2   = 127;

    logic              clk = 1'b0;
    logic              rst;
    logic              rst2;
    logic [2:0]        sym_in;
    logic              sym_valid;
    logic              frame_ack;
    logic [6*CNT_W-1:0] cnt_data,  cnt_data2;
    logic [35:0]       cnt_flag,  cnt_flag2;
    logic [2:0]        cnt_num,   cnt_num2;
    logic              cnt_valid, cnt_valid2;
    logic              busy,      busy2;
    logic              err,       err2;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [35:0] FLAG_EXP = {6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32};

    typedef struct packed {
        logic [0:5][6:0] n;     // n[0] = count of A1 ... n[5] = count of A6
        logic            gaps;
        logic            ill;
        logic            err;
    } frame_t;

    frame_t vec [4];

    always #5 clk = ~clk;

    huffman_histogram #(.FRAME_LEN(FL), .CNT_W(CNT_W), .SYM_N(6)) dut (
        .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid), .frame_ack(frame_ack),
        .cnt_data(cnt_data), .cnt_flag(cnt_flag), .cnt_num(cnt_num),
        .cnt_valid(cnt_valid), .busy(busy), .err(err)
    );

    huffman_histogram #(.FRAME_LEN(FL2), .CNT_W(CNT_W), .SYM_N(6)) dut2 (
        .clk(clk), .rst(rst2), .sym_in(sym_in), .sym_valid(sym_valid), .frame_ack(frame_ack),
        .cnt_data(cnt_data2), .cnt_flag(cnt_flag2), .cnt_num(cnt_num2),
        .cnt_valid(cnt_valid2), .busy(busy2), .err(err2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6*CNT_W-1:0] pack(input logic [0:5][6:0] n);
        logic [6*CNT_W-1:0] d;
        d = '0;
        for (int k = 0; k < 6; k++) d[CNT_W*(5-k) +: CNT_W] = n[k];
        return d;
    endfunction

    // Advance one edge; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] s);
        sym_in    = s;
        sym_valid = 1'b1;
        step();
        sym_valid = 1'b0;
    endtask

    task automatic chk_step(input int sent);
        chk("valid_timing", 64'(cnt_valid), 64'(sent == FL));
        chk("busy_timing",  64'(busy),      64'(sent > 0 && sent < FL));
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
        chk("ack_counts", 64'(cnt_data), 64'd0);
        chk("ack_valid",  64'(cnt_valid), 64'd0);
        chk("ack_err",    64'(err), 64'd0);
    endtask

    // Sends one frame in symbol order A1..A6, optionally with idle gaps and illegal codes.
    task automatic run_frame(input frame_t f);
        int sent  = 0;
        int ill_i = 0;
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < int'(f.n[k]); j++) begin
                if (f.gaps && (sent % 7 == 3)) begin
                    step();
                    chk_step(sent);
                end
                if (f.ill && (sent % 11 == 5)) begin
                    send((ill_i % 2 == 1) ? 3'd7 : 3'd0);
                    ill_i++;
                    chk_step(sent);
                end
                send(3'(k + 1));
                sent++;
                chk_step(sent);
            end
        end
        chk("frame_counts", 64'(cnt_data), 64'(pack(f.n)));
        chk("frame_err",    64'(err), 64'(f.err));
    endtask

    initial begin
        vec[0].n = {7'd40, 7'd20, 7'd15, 7'd10, 7'd10, 7'd5};
        vec[0].gaps = 1'b0; vec[0].ill = 1'b0; vec[0].err = 1'b0;
        vec[1].n = {7'd40, 7'd20, 7'd15, 7'd10, 7'd10, 7'd5};
        vec[1].gaps = 1'b1; vec[1].ill = 1'b1; vec[1].err = 1'b1;
        vec[2].n = {7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd100};
        vec[2].gaps = 1'b0; vec[2].ill = 1'b0; vec[2].err = 1'b0;
        vec[3].n = {7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd85};
        vec[3].gaps = 1'b0; vec[3].ill = 1'b1; vec[3].err = 1'b1;

        rst = 1'b1; rst2 = 1'b1;
        sym_in = 3'd0; sym_valid = 1'b0; frame_ack = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_counts", 64'(cnt_data), 64'd0);
        chk("rst_valid",  64'(cnt_valid), 64'd0);
        chk("rst_busy",   64'(busy), 64'd0);
        chk("rst_err",    64'(err), 64'd0);
        chk("rst_flag",   64'(cnt_flag), 64'(FLAG_EXP));
        chk("rst_num",    64'(cnt_num), 64'd6);

        // Ack outside DONE is ignored: counts persist after an ack mid-frame.
        send(3'd4);
        frame_ack = 1'b1;
        send(3'd4);
        frame_ack = 1'b0;
        chk("ack_ignored_busy", 64'(busy), 64'd1);
        chk("ack_ignored_cnt",  64'(cnt_data), 64'(pack({7'd0, 7'd0, 7'd0, 7'd2, 7'd0, 7'd0})));
        rst = 1'b1; step(); rst = 1'b0;

        for (int t = 0; t < 4; t++) begin
            run_frame(vec[t]);
            ack();
        end

        // Hold in DONE for 5 cycles with 3 extra A1 symbols, then release.
        run_frame(vec[0]);
        for (int c = 0; c < 5; c++) begin
            sym_in = 3'd1;
            sym_valid = (c < 3);
            step();
            chk("hold_counts", 64'(cnt_data), 64'(pack(vec[0].n)));
            chk("hold_valid",  64'(cnt_valid), 64'd1);
        end
        sym_valid = 1'b0;
        chk("hold_err", 64'(err), 64'd1);
        ack();
        chk("ack_busy", 64'(busy), 64'd0);
        run_frame(vec[2]);
        ack();

        // Symbol on the releasing edge is dropped without flagging an error.
        run_frame(vec[0]);
        frame_ack = 1'b1;
        send(3'd2);
        frame_ack = 1'b0;
        chk("same_edge_err",   64'(err), 64'd0);
        chk("same_edge_cnt",   64'(cnt_data), 64'd0);
        chk("same_edge_valid", 64'(cnt_valid), 64'd0);
        run_frame(vec[0]);
        ack();

        // Reset mid-frame discards 57 counted symbols.
        for (int i = 0; i < 57; i++) send(3'd1);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_counts", 64'(cnt_data), 64'd0);
        chk("mid_rst_busy",   64'(busy), 64'd0);
        chk("mid_rst_valid",  64'(cnt_valid), 64'd0);
        run_frame(vec[0]);
        ack();

        // 127-symbol frame on the second instance: no wrap at the top of the count range.
        rst2 = 1'b0;
        for (int i = 0; i < FL2; i++) begin
            send(3'd3);
            chk("f127_valid", 64'(cnt_valid2), 64'(i == FL2 - 1));
            chk("f127_flag",  64'(cnt_flag2), 64'(FLAG_EXP));
            chk("f127_num",   64'(cnt_num2), 64'd6);
        end
        chk("f127_counts", 64'(cnt_data2), 64'(pack({7'd0, 7'd0, 7'd127, 7'd0, 7'd0, 7'd0})));
        chk("f127_slot3",  64'(cnt_data2[3*CNT_W +: CNT_W]), 64'd127);
        chk("f127_err",    64'(err2), 64'd0);
        chk("f127_busy",   64'(busy2), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/huffman_histogram.md
Name: huffman_histogram

Overview:
- Upstream stage of the Huffman encoder. Counts occurrences of six symbols A1..A6 over a fixed-length input frame.
- At frame end it presents the packed counts and one-hot group flags for the sort stage to load, and asserts cnt_valid.
- It then holds the result until the controller acknowledges, and starts a new frame after that.

Parameters:
- FRAME_LEN, 100, number of legal symbols per frame; legal range 2..127.
- CNT_W, 7, width of each per-symbol count; matches the sort-stage data width.
- SYM_N, 6, number of symbols; fixed, not to be overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- sym_in  in  3  symbol code; 1..6 = A1..A6; 0 and 7 are illegal.
- sym_valid  in  1  sym_in is valid this cycle.
- frame_ack  in  1  controller has loaded the result; release the hold.
- cnt_data  out  6*CNT_W  packed counts.
  - Slot i occupies bits [CNT_W*(i+1)-1 : CNT_W*i].
  - Slot 5 (MSB) = A1, slot 4 = A2, ..., slot 0 = A6.
- cnt_flag  out  6*6  packed one-hot flags, same slot order.
  - Slot for Ak holds a 6-bit value with only bit k-1 set.
  - Slot 5 = 6'b000001, slot 0 = 6'b100000.
- cnt_num  out  3  number of entries to sort; constant 3'd6.
- cnt_valid  out  1  result complete and held.
- busy  out  1  high while a frame is partially counted.
- err  out  1  sticky flag: an illegal symbol, or a symbol while cnt_valid is high, was seen this frame.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All counts = 0, total = 0, state = IDLE.
  - cnt_valid = 0, busy = 0, err = 0.
  - cnt_flag and cnt_num are constants and are unaffected by reset.
  - Reset mid-frame or in DONE discards everything; no partial result is output.
- State machine: IDLE -> COUNT -> DONE -> IDLE.
- IDLE:
  - A legal symbol with sym_valid=1 is counted that edge; next state COUNT, busy=1.
  - An illegal symbol sets err; the state stays IDLE.
- COUNT:
  - Each legal sym_valid increments the matching count and the internal total (7-bit) by 1 at that edge.
  - Illegal symbols set err; they increment neither a count nor total.
  - When total reaches FRAME_LEN at this edge, next state is DONE.
- DONE:
  - cnt_valid=1 and busy=0, both registered. cnt_valid rises on the cycle after the edge that accepted symbol number FRAME_LEN.
  - cnt_data is stable throughout DONE.
  - sym_valid=1 in DONE: the symbol is dropped and err is set.
  - frame_ack=1: at that edge all counts and total clear to 0, err clears, cnt_valid -> 0, next state IDLE.
  - A symbol arriving in the same cycle as frame_ack is dropped and does NOT set err.
  - frame_ack outside DONE is ignored.
- Counts:
  - Unsigned; the sum of the six counts always equals total.
  - Each count saturates at 2^CNT_W-1; unreachable while FRAME_LEN<=127.
- cnt_data is driven directly from the count registers in every state, so partial counts are visible while busy=1.
- Throughput: one symbol per clock; no back-pressure. The producer must not rely on symbols sent during DONE.
- The FRAME_LEN=1 corner is excluded by the parameter range.

Test Plan:
- Reset, then 100 symbols: A1 x40, A2 x20, A3 x15, A4 x10, A5 x10, A6 x5, back-to-back.
  - cnt_valid rises on the cycle after the 100th symbol.
  - cnt_data slots 5..0 = 40,20,15,10,10,5; err=0; busy fell with cnt_valid.
- Same frame with sym_valid gaps and symbols 0 and 7 inserted.
  - Identical counts; cnt_valid is delayed only by the gaps; err=1.
- In DONE, hold 5 cycles while sending 3 more A1 symbols; then pulse frame_ack.
  - During the hold: counts unchanged, err=1.
  - After the ack edge: all counts 0, cnt_valid=0, err=0, IDLE.
  - A following 100-symbol all-A6 frame gives slot 0 = 100 and all other slots 0.
- frame_ack in the same cycle as a sym_valid A2.
  - The A2 is dropped; the next frame's A2 count excludes it; err stays 0.
- Assert rst after 57 symbols.
  - Next cycle: counts 0, busy=0, cnt_valid=0.
  - A fresh 100-symbol frame completes at exactly 100 symbols, not 43.
- FRAME_LEN=127 with 127 A3 symbols.
  - Slot 3 = 127 with no wrap; cnt_valid asserts.
  - cnt_flag slot 3 = 6'b000100 and cnt_num = 6 throughout.
